ram_rwsp_128x6: RTL and testbench
=================================

Name: ram_rwsp_128x6

Overview:
- 128-entry x 6-bit, one-write-port / one-read-port synchronous RAM with a pipelined read: read-address stage (re) plus output-register stage (ore).
- Storage macro used under the CDMA weight FIFO (and similar fifos). Includes a power-down control bus.
- Single clock domain. The FIFO controller guarantees pointer ordering; the RAM adds no flow control.

Parameters:
- FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, default 1, simulation-only.
  - 1: same-address read/write contention warning is also checked while reset_ is asserted.
  - 0: contention warning is suppressed during reset.
  - No effect on synthesized logic or data.

Ports:
- clk  input  1  sole clock, all state on rising edge
- reset_  input  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
- pwrbus_ram_pd  input  32  power-down bus; nonzero = array powered down
- wa  input  7  write address
- we  input  1  write enable
- di  input  6  write data
- ra  input  7  read address
- re  input  1  read enable (stage 1)
- ore  input  1  output-register enable (stage 2)
- dout  output  6  registered read data

Behaviour:
- Array: 128 x 6 storage, no reset. Contents are undefined (X in simulation) until written.
- Write: at a clk edge with we=1 and pwrbus_ram_pd==0, mem[wa] <= di. One-cycle write latency: data is readable by a re issued the following cycle.
- Read stage 1: at a clk edge with re=1 and pwrbus_ram_pd==0, rd_q <= mem[ra]. With re=0, rd_q holds.
- Read stage 2: at a clk edge with ore=1, dout <= rd_q. With ore=0, dout holds.
- re and ore in the same cycle: dout receives the old rd_q (value before this edge's update). It is a true 2-deep pipeline; a fresh re reaches dout at the first ore edge after it.
- Reset: while reset_=1 at an edge, rd_q <= 0 and dout <= 0. Writes and reads are ignored. Array contents are preserved. Reset takes priority over re, ore and we.
- Same address read and write in one cycle (re=1, we=1, ra==wa): without the optional feature, rd_q gets the OLD mem value (read-first). In simulation a contention warning is printed, subject to the parameter.
- Addresses are 7 bits, so all 128 values are valid. No wrap logic is needed: the address is the index.
- Power-down (pwrbus_ram_pd != 0):
  - Writes are blocked and re is ignored (rd_q holds).
  - ore still operates, so dout can capture rd_q.
  - Array contents are retained (retention model).
  - Returning to 0 resumes normal operation next cycle.
- X handling (simulation): if we or re is X, or the address is X while enabled, the affected target becomes all-X. Synthesis treats these as don't-care.

Optional Feature:
- Macro RAM_WR_BYPASS_EN.
- Defined: same-cycle same-address read and write returns the NEW data (write-first). rd_q <= di, with no contention warning.
- Undefined: read-first behaviour as above, with the warning.
- All other behaviour is identical either way.

Test Plan:
- Reset: hold reset_=1 for 2 cycles with re=ore=we=1 -> dout=6'h00 and no array write occurs. After release, reading an address written before reset returns its old value.
- Basic pipeline:
  - Write 6'h2A@5.
  - Next cycle: re=1, ra=5.
  - Following cycle: ore=1 -> dout=6'h2A one edge after ore.
  - dout holds 6'h2A while ore=0.
- Full sweep: write mem[i]=i[5:0]^6'h15 for i=0..127, then stream re/ore back-to-back over ra=0..127 -> dout sequence matches with 1-cycle stage spacing. Addresses 127 and 0 are both correct.
- Contention: mem[9]=6'h01; same cycle we=1, wa=9, di=6'h3E and re=1, ra=9; then ore -> dout=6'h01 without the macro, 6'h3E with RAM_WR_BYPASS_EN. Subsequent read of 9 returns 6'h3E either way.
- Power-down: pwrbus_ram_pd=32'h1 with we=1, wa=3, di=6'h3F (mem[3]=6'h07) and re=1 -> rd_q unchanged. After pd=0, reading 3 returns 6'h07.
- Simultaneous re/ore: rd_q=6'h11; re on address holding 6'h22 and ore in the same cycle -> dout=6'h11. Next ore -> dout=6'h22.

Source files
------------

// File: rtl/ram_rwsp_128x6.sv
// 128x6 one-write/one-read synchronous RAM with a two-stage read pipeline (re -> rd_q, ore -> dout).
// Optional macro RAM_WR_BYPASS_EN makes same-address read/write return the new data.
module ram_rwsp_128x6 #(
    parameter int FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [31:0] pwrbus_ram_pd,
    input  logic [6:0]  wa,
    input  logic        we,
    input  logic [5:0]  di,
    input  logic [6:0]  ra,
    input  logic        re,
    input  logic        ore,
    output logic [5:0]  dout
);

    logic [5:0] mem [0:127];
    logic [5:0] rd_q;
    logic       pwr_on;
    logic       wr_en;
    logic       rd_en;
    logic       rw_collide;

    assign pwr_on     = (pwrbus_ram_pd == 32'd0);
    assign wr_en      = !reset_ && pwr_on && we;
    assign rd_en      = !reset_ && pwr_on && re;
    assign rw_collide = rd_en && wr_en && (ra == wa);

    // Array has no reset; contents survive reset and power-down.
    always_ff @(posedge clk) begin
`ifndef SYNTHESIS
        if (!reset_ && pwr_on && ($isunknown(we) || (we && $isunknown(wa)))) begin
            if ($isunknown(wa)) begin
                for (int i = 0; i < 128; i++) mem[i] <= 'x;
            end else begin
                mem[wa] <= 'x;
            end
        end else
`endif
        if (wr_en) begin
            mem[wa] <= di;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            rd_q <= 6'd0;
        end
`ifndef SYNTHESIS
        else if (pwr_on && ($isunknown(re) || (re && $isunknown(ra)))) begin
            rd_q <= 'x;
        end
`endif
        else if (rd_en) begin
`ifdef RAM_WR_BYPASS_EN
            if (rw_collide) begin
                rd_q <= di;
            end else begin
                rd_q <= mem[ra];
            end
`else
            rd_q <= mem[ra];
`endif
        end
    end

    // Stage 2 ignores power-down so a pending rd_q can still be drained.
    always_ff @(posedge clk) begin
        if (reset_) begin
            dout <= 6'd0;
        end else if (ore) begin
            dout <= rd_q;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (pwr_on && re && we && (ra == wa)
            && (!reset_ || (FORCE_CONTENTION_ASSERTION_RESET_ACTIVE != 0))) begin
`ifndef RAM_WR_BYPASS_EN
            $warning("ram_rwsp_128x6: read/write contention at address %0d", ra);
`endif
        end
    end
`endif

endmodule

// File: tb/tb_ram_rwsp_128x6.sv
// Directed bench for ram_rwsp_128x6: reset, pipeline timing, sweep, contention, power-down.
// Honours RAM_WR_BYPASS_EN for the contention expectation.
module tb_ram_rwsp_128x6;

    logic        clk = 1'b0;
    logic        reset_;
    logic [31:0] pwrbus_ram_pd;
    logic [6:0]  wa;
    logic        we;
    logic [5:0]  di;
    logic [6:0]  ra;
    logic        re;
    logic        ore;
    logic [5:0]  dout;

    int checks = 0;
    int passes = 0;

    ram_rwsp_128x6 dut (
        .clk           (clk),
        .reset_        (reset_),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .wa            (wa),
        .we            (we),
        .di            (di),
        .ra            (ra),
        .re            (re),
        .ore           (ore),
        .dout          (dout)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; one posedge later outputs are sampled at the next negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        checks++;
        assert (dout === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, dout, exp);
    endtask

    task automatic wr(input logic [6:0] a, input logic [5:0] d);
        we = 1'b1; wa = a; di = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        re = 1'b1; ra = a;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
    endtask

    logic [5:0] exp_collide;

    initial begin
        reset_ = 1'b0; pwrbus_ram_pd = 32'd0;
        wa = '0; we = 1'b0; di = '0; ra = '0; re = 1'b0; ore = 1'b0;
        @(negedge clk);

        // Reset: written value must survive, outputs cleared, writes blocked.
        wr(7'd20, 6'h2C);
        reset_ = 1'b1; re = 1'b1; ore = 1'b1; we = 1'b1; wa = 7'd20; di = 6'h11; ra = 7'd20;
        tick();
        tick();
        check("reset_dout", 6'h00);
        reset_ = 1'b0; re = 1'b0; we = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
        check("reset_rdq_cleared", 6'h00);
        rd(7'd20);
        check("reset_retain", 6'h2C);

        // Basic pipeline, one-cycle write latency, hold with ore=0.
        wr(7'd5, 6'h2A);
        re = 1'b1; ra = 7'd5;
        tick();
        re = 1'b0;
        check("stage1_only", 6'h2C);
        ore = 1'b1;
        tick();
        ore = 1'b0;
        check("basic_read", 6'h2A);
        tick();
        tick();
        check("basic_hold", 6'h2A);

        // Full sweep with back-to-back streaming reads.
        for (int i = 0; i < 128; i++) begin
            wr(7'(i), 6'(i) ^ 6'h15);
        end
        for (int k = 0; k <= 128; k++) begin
            re  = (k < 128);
            ra  = 7'(k);
            ore = (k >= 1);
            tick();
            if (k >= 1) check($sformatf("sweep_%0d", k - 1), 6'(k - 1) ^ 6'h15);
        end
        re = 1'b0; ore = 1'b0;

        // Same-address contention.
`ifdef RAM_WR_BYPASS_EN
        exp_collide = 6'h3E;
`else
        exp_collide = 6'h01;
`endif
        wr(7'd9, 6'h01);
        we = 1'b1; wa = 7'd9; di = 6'h3E; re = 1'b1; ra = 7'd9;
        tick();
        we = 1'b0; re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
        check("contention", exp_collide);
        rd(7'd9);
        check("contention_after", 6'h3E);

        // Power-down: write blocked, re ignored, ore still drains rd_q.
        wr(7'd3, 6'h07);
        pwrbus_ram_pd = 32'h1; we = 1'b1; wa = 7'd3; di = 6'h3F; re = 1'b1; ra = 7'd3;
        tick();
        we = 1'b0; re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
        check("pd_rdq_hold", 6'h3E);
        pwrbus_ram_pd = 32'd0;
        rd(7'd3);
        check("pd_retain", 6'h07);

        // Simultaneous re/ore: dout takes the old rd_q.
        wr(7'd40, 6'h11);
        wr(7'd41, 6'h22);
        re = 1'b1; ra = 7'd40;
        tick();
        check("pre_simul_hold", 6'h07);
        ra = 7'd41; ore = 1'b1;
        tick();
        re = 1'b0;
        check("simul_old", 6'h11);
        tick();
        ore = 1'b0;
        check("simul_next", 6'h22);

        // Boundary addresses via individual reads.
        rd(7'd127);
        check("addr_127", 6'h7F ^ 6'h15 & 6'h3F);
        rd(7'd0);
        check("addr_0", 6'h15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
